// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexes four BCD digits onto a 4-digit 7-segment display with a
//   colon and leading-zero blanking. A small view FSM selects between the
//   live count and the captured lap time.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cnt_* (4b x4)     : live count digits (BCD)
//   lap_* (4b x4)     : lap digits (BCD)
//   lap_valid         : one-cycle pulse, new lap captured
//   show_sel          : level, forces the lap view while high
//   running           : level, enables colon blink
//   seg[6:0]          : segments {g,f,e,d,c,b,a}
//   dp                : colon, lit on the ls_hr slot only
//   an[3:0]           : one-hot digit enable, an[3]=ms_hr ... an[0]=ls_min
//   showing_lap       : current frame displays lap digits
//
// Handshake: there is no valid/ready pair here; lap_valid is a single-cycle
// event sampled on every clock, and all other inputs are levels.
//
// Scan order is 3,2,1,0; the tick that moves the index to 3 is the frame
// start. Inputs are snapshotted at that tick so a frame never tears.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int LAP_SHOW     = 250,
  parameter int BLINK_FRAMES = 125,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_ms_hr,
  input  logic [3:0] cnt_ls_hr,
  input  logic [3:0] cnt_ms_min,
  input  logic [3:0] cnt_ls_min,
  input  logic [3:0] lap_ms_hr,
  input  logic [3:0] lap_ls_hr,
  input  logic [3:0] lap_ms_min,
  input  logic [3:0] lap_ls_min,
  input  logic       lap_valid,
  input  logic       show_sel,
  input  logic       running,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       showing_lap
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(LAP_SHOW + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_POL  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic       DP_POL  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    SHOW_CNT = 2'd0,
    SHOW_LAP = 2'd1,
    LAP_HOLD = 2'd2
  } view_t;

  view_t           view_q, view_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   pre_q;
  logic [1:0]      idx_q, idx_n;
  logic            tick, frame_start;
  logic [15:0]     snap_cnt_q, snap_lap_q;
  logic            src_lap_q, run_snap_q, phase_q;
  logic [BW-1:0]   bcnt_q;
  logic [15:0]     live_cnt, live_lap, frame_digits;
  logic            src_lap_n;
  logic [3:0]      cur_dig;
  logic [6:0]      seg_on;
  logic            dp_on;
  logic [3:0]      an_on;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;  // non-BCD code shows a dash
    endcase
  endfunction

  assign tick        = (pre_q == PW'(SCAN_DIV - 1));
  assign frame_start = tick && (idx_q == 2'd0);
  assign idx_n       = idx_q - 2'd1;  // 0 -> 3 -> 2 -> 1 -> 0
  assign live_cnt    = {cnt_ms_hr, cnt_ls_hr, cnt_ms_min, cnt_ls_min};
  assign live_lap    = {lap_ms_hr, lap_ls_hr, lap_ms_min, lap_ls_min};

  // View FSM: transitions happen in the event cycle; the display source
  // follows view_q only at frame start.
  always_comb begin
    view_d = view_q;
    fcnt_d = fcnt_q;
    case (view_q)
      SHOW_CNT: begin
        if (show_sel) begin
          view_d = LAP_HOLD;
        end else if (lap_valid) begin
          view_d = SHOW_LAP;
          fcnt_d = FW'(LAP_SHOW);
        end
      end
      SHOW_LAP: begin
        if (show_sel) begin
          view_d = LAP_HOLD;
        end else if (lap_valid) begin
          fcnt_d = FW'(LAP_SHOW);
        end else if (frame_start) begin
          if (fcnt_q <= FW'(1)) begin
            view_d = SHOW_CNT;
            fcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q - FW'(1);
          end
        end
      end
      LAP_HOLD: begin
        fcnt_d = '0;
        if (!show_sel) view_d = SHOW_CNT;
      end
      default: begin
        view_d = SHOW_CNT;
        fcnt_d = '0;
      end
    endcase
  end

  // At frame start the new snapshot is not yet registered, so the first
  // slot decodes straight from the live inputs that are being captured.
  always_comb begin
    src_lap_n    = frame_start ? (view_q != SHOW_CNT) : src_lap_q;
    frame_digits = frame_start ? (src_lap_n ? live_lap : live_cnt)
                               : (src_lap_q ? snap_lap_q : snap_cnt_q);
    cur_dig      = frame_digits[{idx_n, 2'b00} +: 4];
    if (BLANK_LZ && (idx_n == 2'd3) && (cur_dig == 4'd0)) begin
      seg_on = 7'h00;
    end else begin
      seg_on = decode(cur_dig);
    end
    // The ls_hr slot always follows a frame start, so the run/phase
    // registers already hold this frame's values.
    dp_on = (idx_n == 2'd2) && (!run_snap_q || phase_q);
    an_on = 4'b0001 << idx_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      view_q      <= SHOW_CNT;
      fcnt_q      <= '0;
      pre_q       <= '0;
      idx_q       <= 2'd0;
      snap_cnt_q  <= '0;
      snap_lap_q  <= '0;
      src_lap_q   <= 1'b0;
      run_snap_q  <= 1'b0;
      phase_q     <= 1'b1;
      bcnt_q      <= '0;
      seg         <= SEG_POL;
      an          <= AN_POL;
      dp          <= DP_POL;
      showing_lap <= 1'b0;
    end else begin
      view_q <= view_d;
      fcnt_q <= fcnt_d;
      pre_q  <= tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        idx_q <= idx_n;
        seg   <= seg_on ^ SEG_POL;
        an    <= an_on ^ AN_POL;
        dp    <= dp_on ^ DP_POL;
      end
      if (frame_start) begin
        snap_cnt_q  <= live_cnt;
        snap_lap_q  <= live_lap;
        src_lap_q   <= src_lap_n;
        showing_lap <= src_lap_n;
        run_snap_q  <= running;
        if (!running) begin
          phase_q <= 1'b1;
          bcnt_q  <= '0;
        end else if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
          phase_q <= ~phase_q;
          bcnt_q  <= '0;
        end else begin
          bcnt_q <= bcnt_q + BW'(1);
        end
      end
    end
  end

endmodule
